mdmhc_encoder_pipe: RTL and testbench

- Parametrised, pipelined successor of the combinational MDMHC encoder.
- Splits a DATA_W-bit word into 4-bit symbols arranged as a ROWS x COLS matrix and produces one codeword per word. The codeword carries:
  - per-symbol Hamming bits
  - horizontal adder parity
  - vertical XOR parity
  - the raw data
- Adds a valid/ready handshake, a 2-stage pipeline, per-word parity-suppression modes and an output word counter.
- Sits between a core's store path and the NoC/memory write port.

---
 rtl/mdmhc_encoder_pipe_if.sv | 35 +++
 rtl/mdmhc_encoder_pipe.sv | 122 ++++++++++++
 tb/tb_mdmhc_encoder_pipe.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdmhc_encoder_pipe_if.sv
// rtl/mdmhc_encoder_pipe_if.sv - word-in / codeword-out handshake bundle for mdmhc_encoder_pipe
//
// Purpose: carries the input word channel (in_valid/in_ready/in_data/in_mode)
// and the output codeword channel (out_valid/out_ready/out_data).
// Ports (signals):
//   in_valid  producer has a word         in_ready  encoder can take it
//   in_data   DATA_W-bit word             in_mode   per-word suppression mode
//   out_valid codeword present            out_ready consumer takes it
//   out_data  ENC_W-bit codeword
// Modports: slave = encoder side, master = producer/consumer side.

interface mdmhc_encoder_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 2
);
  localparam int ENC_W = 8 * (DATA_W / 4) + DATA_W / ROWS + DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [ENC_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mdmhc_encoder_pipe.sv
// rtl/mdmhc_encoder_pipe.sv - two-stage pipelined MDMHC codeword encoder
//
// Purpose: splits each DATA_W-bit word into 4-bit symbols laid out as a
// ROWS x COLS matrix and emits {hamming, horizontal sums, vertical xor, data}.
// Stage 1 holds the raw word and its mode, stage 2 holds the finished codeword.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        handshake bundle (slave side): word in, codeword out
//   out_count  delivered codewords, wraps modulo 2^CNT_W
//   busy       a word is held in either stage

module mdmhc_encoder_pipe #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mdmhc_encoder_pipe_if.slave  bus,
  output logic [CNT_W-1:0]     out_count,
  output logic                 busy
);

  localparam int NSYM  = DATA_W / 4;
  localparam int COLS  = NSYM / ROWS;
  localparam int HALF  = COLS / 2;
  localparam int ROW_W = DATA_W / ROWS;
  localparam int HP_W  = 3 * NSYM;
  localparam int H_W   = 5 * NSYM;
  localparam int ENC_W = HP_W + H_W + ROW_W + DATA_W;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_mode;
  logic              s2_valid;
  logic [ENC_W-1:0]  s2_data;
  logic              s2_adv;
  logic              in_ready_int;

  logic [HP_W-1:0]   hp_field;
  logic [H_W-1:0]    h_field;
  logic [ROW_W-1:0]  v_field;
  logic [ENC_W-1:0]  enc;

  // Stage 2 can take a new codeword when empty or when its current one leaves.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign in_ready_int = !s1_valid || s2_adv;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign busy          = s1_valid || s2_valid;

  // Codeword computed from the stage-1 word; the mode travelling with the
  // word blanks whole fields after they are formed.
  always_comb begin
    hp_field = '0;
    h_field  = '0;
    v_field  = '0;

    for (int s = 0; s < NSYM; s++) begin
      hp_field[3*s +: 3] = {s1_data[4*s+1] ^ s1_data[4*s+2] ^ s1_data[4*s+3],
                            s1_data[4*s]   ^ s1_data[4*s+2] ^ s1_data[4*s+3],
                            s1_data[4*s]   ^ s1_data[4*s+1] ^ s1_data[4*s+3]};
    end

    // Lower half of the sums pairs column k with column k+COLS/2; the upper
    // half pairs adjacent columns 2k and 2k+1. Sums are 5 bits so no carry is lost.
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < HALF; k++) begin
        h_field[5*(r*HALF+k) +: 5] =
          {1'b0, s1_data[4*(r*COLS+k) +: 4]} +
          {1'b0, s1_data[4*(r*COLS+k+HALF) +: 4]};
        h_field[5*(NSYM/2+r*HALF+k) +: 5] =
          {1'b0, s1_data[4*(r*COLS+2*k) +: 4]} +
          {1'b0, s1_data[4*(r*COLS+2*k+1) +: 4]};
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      v_field = v_field ^ s1_data[r*ROW_W +: ROW_W];
    end

    if (s1_mode[0]) hp_field = '0;
    if (s1_mode[1]) h_field  = '0;
  end

  assign enc = {hp_field, h_field, v_field, s1_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      out_count <= '0;
    end else begin
      if (in_ready_int) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_mode <= bus.in_mode;
        end
      end

      // out_data only changes when a new word is loaded, so it holds during a stall.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= enc;
        end
      end

      if (s2_valid && bus.out_ready) begin
        out_count <= out_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mdmhc_encoder_pipe.sv
// tb/tb_mdmhc_encoder_pipe.sv - directed self-checking bench for mdmhc_encoder_pipe

module tb_mdmhc_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt_a;
  logic        busy_a;
  logic [3:0]  cnt_b;
  logic        busy_b;
  int          n_cmp = 0;
  int          n_fail = 0;

  localparam logic [39:0] H_BASIC  = 40'b00011_00111_01011_01111_00100_00110_01100_01110;
  localparam logic [23:0] HP_BASIC = 24'h776AC7;

  mdmhc_encoder_pipe_if #(.DATA_W(32), .ROWS(2)) a ();
  mdmhc_encoder_pipe_if #(.DATA_W(64), .ROWS(4)) b ();

  mdmhc_encoder_pipe #(.DATA_W(32), .ROWS(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave), .out_count(cnt_a), .busy(busy_a)
  );

  mdmhc_encoder_pipe #(.DATA_W(64), .ROWS(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave), .out_count(cnt_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic logic [207:0] ref64(input logic [63:0] d, input logic [1:0] m);
    logic [47:0] hp;
    logic [79:0] h;
    logic [15:0] v;
    logic [3:0]  n;
    logic [3:0]  x;
    logic [3:0]  y;
    hp = '0;
    h  = '0;
    v  = '0;
    for (int s = 0; s < 16; s++) begin
      n = d[4*s +: 4];
      hp[3*s +: 3] = {^(n & 4'b1110), ^(n & 4'b1101), ^(n & 4'b1011)};
    end
    for (int r = 0; r < 4; r++) begin
      v = v ^ d[16*r +: 16];
      for (int k = 0; k < 2; k++) begin
        x = d[16*r+4*k +: 4];
        y = d[16*r+4*(k+2) +: 4];
        h[5*(2*r+k) +: 5] = 5'(x) + 5'(y);
        x = d[16*r+8*k +: 4];
        y = d[16*r+8*k+4 +: 4];
        h[5*(8+2*r+k) +: 5] = 5'(x) + 5'(y);
      end
    end
    if (m[0]) hp = '0;
    if (m[1]) h  = '0;
    return {hp, h, v, d};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d, input logic [1:0] m,
                        output logic [111:0] cw, output bit seen);
    seen = 1'b0;
    cw = '0;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.in_data = d;
    a.in_mode = m;
    a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (a.out_valid) begin
        cw = a.out_data;
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a.out_valid); end
    n_cmp++; if (a.out_data !== 112'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", a.out_data); end
    n_cmp++; if (cnt_a !== 16'h0) begin n_fail++; $display("FAIL reset_out_count got %h want 0", cnt_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_b got %b want 0", b.out_valid); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a.in_ready); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    a.in_valid = 1'b1;
    a.in_data = 32'h12345678;
    a.in_mode = 2'd0;
    a.out_ready = 1'b1;
    #1;
    n_cmp++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", a.in_ready); end
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 out_valid got %b want 0", a.out_valid); end
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy_a); end
    @(negedge clk);
    #1;
    n_cmp++; if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2 out_valid got %b want 1", a.out_valid); end
    n_cmp++; if (a.out_data[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL basic_data got %h want 12345678", a.out_data[31:0]); end
    n_cmp++; if (a.out_data[47:32] !== 16'h444C) begin n_fail++; $display("FAIL basic_v got %h want 444c", a.out_data[47:32]); end
    n_cmp++; if (a.out_data[87:48] !== H_BASIC) begin n_fail++; $display("FAIL basic_h got %h want %h", a.out_data[87:48], H_BASIC); end
    n_cmp++; if (a.out_data[111:88] !== HP_BASIC) begin n_fail++; $display("FAIL basic_hp got %h want %h", a.out_data[111:88], HP_BASIC); end
    n_cmp++; if (a.out_data[90:88] !== 3'b111) begin n_fail++; $display("FAIL basic_hp0 got %b want 111", a.out_data[90:88]); end
    @(negedge clk);
    #1;
    n_cmp++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", cnt_a); end
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", a.out_valid); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", busy_a); end
  endtask

  task automatic test_all_ones();
    logic [111:0] cw;
    bit seen;
    send_a(32'hFFFFFFFF, 2'd0, cw, seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ones_timeout got %b want 1", seen); end
    n_cmp++; if (cw[87:48] !== {8{5'b11110}}) begin n_fail++; $display("FAIL ones_h got %h want %h", cw[87:48], {8{5'b11110}}); end
    n_cmp++; if (cw[47:32] !== 16'h0000) begin n_fail++; $display("FAIL ones_v got %h want 0", cw[47:32]); end
    n_cmp++; if (cw[111:88] !== 24'hFFFFFF) begin n_fail++; $display("FAIL ones_hp got %h want ffffff", cw[111:88]); end
    n_cmp++; if (cw[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ones_data got %h want ffffffff", cw[31:0]); end
  endtask

  task automatic test_modes();
    logic [111:0] cw;
    logic [23:0]  exp_hp;
    logic [39:0]  exp_h;
    logic [1:0]   mm;
    bit seen;
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      exp_hp = mm[0] ? 24'h0 : HP_BASIC;
      exp_h  = mm[1] ? 40'h0 : H_BASIC;
      send_a(32'h12345678, mm, cw, seen);
      n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mode%0d_timeout got %b want 1", m, seen); end
      n_cmp++; if (cw[111:88] !== exp_hp) begin n_fail++; $display("FAIL mode%0d_hp got %h want %h", m, cw[111:88], exp_hp); end
      n_cmp++; if (cw[87:48] !== exp_h) begin n_fail++; $display("FAIL mode%0d_h got %h want %h", m, cw[87:48], exp_h); end
      n_cmp++; if (cw[47:32] !== 16'h444C) begin n_fail++; $display("FAIL mode%0d_v got %h want 444c", m, cw[47:32]); end
      n_cmp++; if (cw[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL mode%0d_data got %h want 12345678", m, cw[31:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  w [5];
    logic [111:0] held;
    bit stalled;
    int sent, got, drop_at;
    w[0] = 32'h0000_0001; w[1] = 32'hA5A5_5A5A; w[2] = 32'h1234_5678;
    w[3] = 32'hFFFF_0000; w[4] = 32'h0F0F_F0F0;
    reset_dut();
    sent = 0; got = 0; drop_at = -1; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      a.out_ready = (cyc >= 4);
      a.in_valid = (sent < 5);
      if (sent < 5) begin
        a.in_data = w[sent];
        a.in_mode = 2'd0;
      end
      #1;
      if (a.in_valid && !a.in_ready && drop_at < 0) drop_at = sent;
      if (a.out_valid && !a.out_ready) begin
        if (stalled) begin
          n_cmp++; if (a.out_data !== held) begin n_fail++; $display("FAIL stall_stable got %h want %h", a.out_data, held); end
        end
        held = a.out_data;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (a.out_valid && a.out_ready) begin
        n_cmp++; if (a.out_data[31:0] !== w[got]) begin n_fail++; $display("FAIL order_word%0d got %h want %h", got, a.out_data[31:0], w[got]); end
        n_cmp++; if (a.out_data[47:32] !== (w[got][15:0] ^ w[got][31:16])) begin n_fail++; $display("FAIL order_v%0d got %h want %h", got, a.out_data[47:32], w[got][15:0] ^ w[got][31:16]); end
        got++;
      end
      if (a.in_valid && a.in_ready) sent++;
    end
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    n_cmp++; if (drop_at !== 2) begin n_fail++; $display("FAIL bp_ready_drop accepts got %0d want 2", drop_at); end
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL bp_words got %0d want 5", got); end
    n_cmp++; if (cnt_a !== 16'd5) begin n_fail++; $display("FAIL bp_count got %0d want 5", cnt_a); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    a.out_ready = 1'b0;
    a.in_valid = 1'b1;
    a.in_data = 32'hDEAD_BEEF;
    a.in_mode = 2'd0;
    @(negedge clk);
    a.in_data = 32'hCAFE_F00D;
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    n_cmp++; if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", a.out_valid); end
    n_cmp++; if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_full got %b want 0", a.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", a.out_valid); end
    n_cmp++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", cnt_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy_a); end
    rst = 1'b0;
    a.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (a.out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %b want 0", seen); end
  endtask

  task automatic test_wrap_sweep();
    logic [63:0]  w [17];
    logic [1:0]   m [17];
    logic [207:0] exp;
    logic [79:0]  h_hand;
    int sent, got;
    w[0] = 64'h1;
    m[0] = 2'd0;
    for (int i = 1; i < 17; i++) begin
      w[i] = {$urandom, $urandom};
      m[i] = 2'($urandom_range(0, 3));
    end
    h_hand = 80'h1 | (80'h1 << 40);
    reset_dut();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 17; cyc++) begin
      @(negedge clk);
      b.out_ready = 1'b1;
      b.in_valid = (sent < 17);
      if (sent < 17) begin
        b.in_data = w[sent];
        b.in_mode = m[sent];
      end
      #1;
      if (b.out_valid && b.out_ready) begin
        if (got == 0) begin
          n_cmp++; if (b.out_data[207:160] !== 48'h3) begin n_fail++; $display("FAIL w64_hp got %h want 3", b.out_data[207:160]); end
          n_cmp++; if (b.out_data[159:80] !== h_hand) begin n_fail++; $display("FAIL w64_h got %h want %h", b.out_data[159:80], h_hand); end
          n_cmp++; if (b.out_data[79:64] !== 16'h0001) begin n_fail++; $display("FAIL w64_v got %h want 1", b.out_data[79:64]); end
        end
        exp = ref64(w[got], m[got]);
        n_cmp++; if (b.out_data !== exp) begin n_fail++; $display("FAIL w64_word%0d got %h want %h", got, b.out_data, exp); end
        got++;
      end
      if (b.in_valid && b.in_ready) sent++;
    end
    @(negedge clk);
    b.in_valid = 1'b0;
    #1;
    n_cmp++; if (got !== 17) begin n_fail++; $display("FAIL wrap_words got %0d want 17", got); end
    n_cmp++; if (cnt_b !== 4'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", cnt_b); end
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.in_mode = 2'd0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_mode = 2'd0; b.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_ones();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_wrap_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
